// File: rtl/syscall_console.sv
// Syscall console/exit service: print-char, print-int (decimal), exit, exit2.
// Output bytes are queued in a show-ahead FIFO and drained over a ready/valid stream.
`timescale 1ns/1ps
module syscall_console #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        syscall_valid,
  input  logic [31:0] syscall_funct,
  input  logic [31:0] syscall_param1,
  output logic        syscall_busy,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        bad_syscall,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDiv  = 2'd1;
  localparam logic [1:0] StPush = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          neg_q, neg_d;
  logic [31:0]   mag_q, mag_d;
  logic [3:0]    ndig_q, ndig_d;
  logic [3:0]    stk_q [11];
  logic [3:0]    stk_d [11];
  logic          halted_q, halted_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic          bad_q, bad_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          is_char, is_int, accept, act;
  logic [CW-1:0] free_cnt;
  logic [31:0]   mag_div;
  logic [3:0]    digit;
  logic          push, pop;
  logic [7:0]    push_byte;

  assign is_char  = (syscall_funct == 32'd11);
  assign is_int   = (syscall_funct == 32'd1);
  assign free_cnt = CW'(FIFO_DEPTH) - count_q;

  // Print-int reserves worst-case room (sign + 10 digits) up front so PUSH never stalls.
  assign syscall_busy = !halted_q &&
                        ((state_q != StIdle) ||
                         (is_char && (count_q == CW'(FIFO_DEPTH))) ||
                         (is_int && (free_cnt < CW'(11))));

  assign accept  = syscall_valid && !syscall_busy;
  assign act     = accept && !halted_q;
  assign mag_div = mag_q / 32'd10;
  assign digit   = 4'(mag_q % 32'd10);

  assign tx_valid    = (count_q != '0);
  assign tx_data     = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop         = tx_valid && tx_ready;
  assign halted      = halted_q;
  assign exit_code   = exit_code_q;
  assign bad_syscall = bad_q;

  always_comb begin
    state_d     = state_q;
    neg_d       = neg_q;
    mag_d       = mag_q;
    ndig_d      = ndig_q;
    stk_d       = stk_q;
    halted_d    = halted_q;
    exit_code_d = exit_code_q;
    bad_d       = bad_q;
    push        = 1'b0;
    push_byte   = 8'h00;
    case (state_q)
      StIdle: begin
        if (act) begin
          case (syscall_funct)
            32'd11: begin
              push      = 1'b1;
              push_byte = syscall_param1[7:0];
            end
            32'd1: begin
              neg_d   = syscall_param1[31];
              mag_d   = syscall_param1[31] ? (~syscall_param1 + 32'd1) : syscall_param1;
              ndig_d  = 4'd0;
              state_d = StDiv;
            end
            32'd10: begin
              halted_d    = 1'b1;
              exit_code_d = 32'd0;
            end
            32'd17: begin
              halted_d    = 1'b1;
              exit_code_d = syscall_param1;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      StDiv: begin
        // Digits stack LSD first; popping later emits MSD first.
        stk_d[ndig_q] = digit;
        ndig_d        = ndig_q + 4'd1;
        mag_d         = mag_div;
        if (mag_div == 32'd0) state_d = StPush;
      end
      StPush: begin
        push = 1'b1;
        if (neg_q) begin
          push_byte = 8'h2D;
          neg_d     = 1'b0;
        end else begin
          push_byte = {4'h3, stk_q[ndig_q - 4'd1]};
          ndig_d    = ndig_q - 4'd1;
          if (ndig_q == 4'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      neg_q       <= 1'b0;
      mag_q       <= 32'd0;
      ndig_q      <= 4'd0;
      for (int i = 0; i < 11; i++) stk_q[i] <= 4'd0;
      halted_q    <= 1'b0;
      exit_code_q <= 32'd0;
      bad_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      neg_q       <= neg_d;
      mag_q       <= mag_d;
      ndig_q      <= ndig_d;
      stk_q       <= stk_d;
      halted_q    <= halted_d;
      exit_code_q <= exit_code_d;
      bad_q       <= bad_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: tx_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console: randomized syscalls against a
// string-level reference model of the console byte stream and busy timing.
`timescale 1ns/1ps
module tb_syscall_console;

  logic        clock;
  logic        reset_n;
  logic        syscall_valid;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param1;
  logic        syscall_busy;
  logic        halted;
  logic [31:0] exit_code;
  logic        bad_syscall;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  syscall_console #(.FIFO_DEPTH(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .syscall_valid (syscall_valid),
    .syscall_funct (syscall_funct),
    .syscall_param1(syscall_param1),
    .syscall_busy  (syscall_busy),
    .halted        (halted),
    .exit_code     (exit_code),
    .bad_syscall   (bad_syscall),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready)
  );

  int vec;
  int err;
  byte unsigned exp_q[$];
  byte unsigned rx_q[$];
  logic halted_m;
  bit rnd_ready;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bytes are recorded at the negedge before the edge that pops them.
  always @(negedge clock) if (reset_n && tx_valid && tx_ready) rx_q.push_back(tx_data);

  always @(posedge clock) begin
    #1;
    if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic string dec(input logic [31:0] v);
    return $sformatf("%0d", $signed(v));
  endfunction

  function automatic int int_busy(input logic [31:0] v);
    string s = dec(v);
    return 2 * s.len() - (v[31] ? 1 : 0);
  endfunction

  function automatic bit streams_equal();
    if (exp_q.size() != rx_q.size()) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i] != rx_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_accept(input logic [31:0] f, input logic [31:0] p);
    string s;
    if (halted_m) return;
    case (f)
      32'd11: exp_q.push_back(p[7:0]);
      32'd1: begin
        s = dec(p);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      end
      32'd10, 32'd17: halted_m = 1'b1;
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    syscall_valid = 1'b0; syscall_funct = '0; syscall_param1 = '0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_q.delete(); rx_q.delete(); halted_m = 1'b0;
  endtask

  // Present a request until accepted; returns cycles waited (-1 on timeout)
  // and the number of busy cycles that follow acceptance.
  task automatic issue(input logic [31:0] f, input logic [31:0] p,
                       output int wait_cyc, output int busy_cyc);
    @(posedge clock); #1;
    syscall_valid = 1'b1; syscall_funct = f; syscall_param1 = p;
    wait_cyc = 0;
    busy_cyc = 0;
    @(negedge clock);
    while (syscall_busy && wait_cyc < 200) begin
      wait_cyc++;
      @(negedge clock);
    end
    if (syscall_busy) begin
      wait_cyc = -1;
      busy_cyc = -1;
      @(posedge clock); #1;
      syscall_valid = 1'b0; syscall_funct = '0; syscall_param1 = '0;
      return;
    end
    model_accept(f, p);
    @(posedge clock); #1;
    syscall_valid = 1'b0; syscall_funct = '0; syscall_param1 = '0;
    @(negedge clock);
    while (syscall_busy && busy_cyc < 100) begin
      busy_cyc++;
      @(negedge clock);
    end
  endtask

  task automatic drain(output bit timed_out);
    int n = 0;
    @(posedge clock); #1;
    tx_ready = 1'b1;
    @(negedge clock);
    while ((tx_valid || syscall_busy) && n < 300) begin
      n++;
      @(negedge clock);
    end
    timed_out = (n >= 300);
    @(posedge clock); #1;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    syscall_valid = 1'b0; syscall_funct = '0; syscall_param1 = '0;
    tx_ready = 1'b0; rnd_ready = 1'b0; halted_m = 1'b0;
    repeat (2) @(negedge clock);
    vec++; if (syscall_busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", syscall_busy); end
    vec++; if (halted !== 1'b0) begin err++; $display("FAIL reset_halted got %b want 0", halted); end
    vec++; if (exit_code !== 32'd0) begin err++; $display("FAIL reset_exit_code got %h want 0", exit_code); end
    vec++; if (bad_syscall !== 1'b0) begin err++; $display("FAIL reset_bad got %b want 0", bad_syscall); end
    vec++; if (tx_valid !== 1'b0) begin err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    vec++; if (tx_data !== 8'h00) begin err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    @(posedge clock); #1 reset_n = 1'b1;
  endtask

  task automatic test_char_timing();
    do_reset();
    tx_ready = 1'b1;
    @(posedge clock); #1;
    syscall_valid = 1'b1; syscall_funct = 32'd11; syscall_param1 = 32'h0000_0041;
    @(negedge clock);
    vec++; if (syscall_busy !== 1'b0) begin err++; $display("FAIL char_busy got %b want 0", syscall_busy); end
    @(posedge clock); #1;
    syscall_valid = 1'b0; syscall_funct = '0; syscall_param1 = '0;
    @(negedge clock);
    vec++; if (tx_valid !== 1'b1) begin err++; $display("FAIL char_tx_valid got %b want 1", tx_valid); end
    vec++; if (tx_data !== 8'h41) begin err++; $display("FAIL char_tx_data got %h want 41", tx_data); end
    @(negedge clock);
    vec++; if (tx_valid !== 1'b0) begin err++; $display("FAIL char_empty got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_print_int_fixed();
    logic [31:0] vals [3];
    int w, b;
    bit to;
    vals[0] = 32'h8000_0000; vals[1] = 32'd0; vals[2] = 32'd305;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      issue(32'd1, vals[k], w, b);
      vec++; if (w != 0) begin err++; $display("FAIL int_accept[%0d] waited %0d want 0", k, w); end
      vec++;
      if (b != int_busy(vals[k])) begin
        err++; $display("FAIL int_busy_len[%0d] got %0d want %0d", k, b, int_busy(vals[k]));
      end
      drain(to);
      vec++;
      if (to || !streams_equal()) begin
        err++; $display("FAIL int_stream[%0d] got %0d bytes want \"%s\"", k, rx_q.size(), dec(vals[k]));
      end
    end
  endtask

  task automatic test_random();
    int w, b, kind;
    logic [31:0] p;
    bit to;
    do_reset();
    @(posedge clock); #1 rnd_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: p = $urandom;
        1: p = $urandom_range(0, 999);
        2: p = 32'(-int'($urandom_range(1, 99999)));
        default: p = $urandom_range(32, 126);
      endcase
      if (kind == 3) begin
        issue(32'd11, p, w, b);
        vec++; if (w < 0 || b != 0) begin err++; $display("FAIL rnd_char[%0d] wait %0d busy %0d want busy 0", k, w, b); end
      end else begin
        issue(32'd1, p, w, b);
        vec++;
        if (w < 0 || b != int_busy(p)) begin
          err++; $display("FAIL rnd_int[%0d] %s wait %0d busy %0d want %0d", k, dec(p), w, b, int_busy(p));
        end
      end
    end
    @(posedge clock); #1 rnd_ready = 1'b0;
    drain(to);
    vec++;
    if (to || !streams_equal()) begin
      err++; $display("FAIL rnd_stream got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back_full();
    int w, b, waits;
    bit to;
    do_reset();
    waits = 0;
    for (int i = 0; i < 16; i++) begin
      issue(32'd11, 32'h60 + i, w, b);
      if (w != 0) waits++;
    end
    vec++; if (waits != 0) begin err++; $display("FAIL fill_waits got %0d want 0", waits); end
    @(posedge clock); #1;
    syscall_valid = 1'b1; syscall_funct = 32'd11; syscall_param1 = 32'h70;
    waits = 0;
    repeat (3) begin
      @(negedge clock);
      if (syscall_busy !== 1'b1) waits++;
    end
    vec++; if (waits != 0) begin err++; $display("FAIL full_busy not-busy cycles %0d want 0", waits); end
    @(posedge clock); #1 tx_ready = 1'b1;
    @(negedge clock);
    vec++; if (syscall_busy !== 1'b1) begin err++; $display("FAIL full_pop_cycle_busy got %b want 1", syscall_busy); end
    @(posedge clock); #1 tx_ready = 1'b0;
    @(negedge clock);
    vec++; if (syscall_busy !== 1'b0) begin err++; $display("FAIL after_pop_busy got %b want 0", syscall_busy); end
    model_accept(32'd11, 32'h70);
    @(posedge clock); #1;
    syscall_valid = 1'b1; syscall_funct = 32'd1; syscall_param1 = 32'd5;
    @(negedge clock);
    vec++; if (syscall_busy !== 1'b1) begin err++; $display("FAIL int_held_busy got %b want 1", syscall_busy); end
    @(posedge clock); #1;
    syscall_valid = 1'b0; syscall_funct = '0; tx_ready = 1'b1;
    issue(32'd1, 32'd5, w, b);
    vec++; if (w <= 0) begin err++; $display("FAIL int_held_wait got %0d want >0", w); end
    drain(to);
    vec++;
    if (to || !streams_equal()) begin
      err++; $display("FAIL full_stream got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_exit();
    int w, b;
    bit to;
    do_reset();
    issue(32'd10, 32'd99, w, b);
    vec++; if (halted !== 1'b1) begin err++; $display("FAIL exit_halted got %b want 1", halted); end
    vec++; if (exit_code !== 32'd0) begin err++; $display("FAIL exit_code got %h want 0", exit_code); end
    do_reset();
    issue(32'd11, 32'h78, w, b);
    issue(32'd11, 32'h79, w, b);
    issue(32'd17, 32'd7, w, b);
    vec++; if (halted !== 1'b1) begin err++; $display("FAIL exit2_halted got %b want 1", halted); end
    vec++; if (exit_code !== 32'd7) begin err++; $display("FAIL exit2_code got %h want 7", exit_code); end
    issue(32'd11, 32'h42, w, b);
    vec++; if (w != 0) begin err++; $display("FAIL halted_char_wait got %0d want 0", w); end
    issue(32'd1, 32'h1234, w, b);
    vec++; if (w != 0 || b != 0) begin err++; $display("FAIL halted_int wait %0d busy %0d want 0 0", w, b); end
    issue(32'd4, 32'd0, w, b);
    vec++; if (bad_syscall !== 1'b0) begin err++; $display("FAIL halted_bad got %b want 0", bad_syscall); end
    issue(32'd17, 32'd3, w, b);
    vec++; if (exit_code !== 32'd7) begin err++; $display("FAIL halted_exit_code got %h want 7", exit_code); end
    drain(to);
    vec++;
    if (to || !streams_equal() || exp_q.size() != 2) begin
      err++; $display("FAIL halted_stream got %0d bytes want 2", rx_q.size());
    end
  endtask

  task automatic test_bad();
    int w, b;
    bit to;
    do_reset();
    issue(32'd4, $urandom, w, b);
    vec++; if (bad_syscall !== 1'b1) begin err++; $display("FAIL bad_flag got %b want 1", bad_syscall); end
    vec++; if (halted !== 1'b0) begin err++; $display("FAIL bad_halted got %b want 0", halted); end
    drain(to);
    vec++; if (rx_q.size() != 0) begin err++; $display("FAIL bad_bytes got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_reset_mid_div();
    int w, b;
    bit to;
    do_reset();
    issue(32'd11, 32'h7A, w, b);
    @(posedge clock); #1;
    syscall_valid = 1'b1; syscall_funct = 32'd1; syscall_param1 = 32'd123456789;
    @(posedge clock); #1;
    syscall_valid = 1'b0; syscall_funct = '0; syscall_param1 = '0;
    @(negedge clock);
    vec++; if (syscall_busy !== 1'b1) begin err++; $display("FAIL mid_div_busy got %b want 1", syscall_busy); end
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    vec++; if (syscall_busy !== 1'b0) begin err++; $display("FAIL rst_mid_busy got %b want 0", syscall_busy); end
    vec++; if (tx_valid !== 1'b0) begin err++; $display("FAIL rst_mid_tx_valid got %b want 0", tx_valid); end
    vec++; if (tx_data !== 8'h00) begin err++; $display("FAIL rst_mid_tx_data got %h want 00", tx_data); end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_q.delete(); rx_q.delete(); halted_m = 1'b0;
    issue(32'd11, 32'h43, w, b);
    vec++; if (w != 0 || b != 0) begin err++; $display("FAIL post_rst_char wait %0d busy %0d want 0 0", w, b); end
    drain(to);
    vec++;
    if (to || !streams_equal() || rx_q.size() != 1) begin
      err++; $display("FAIL post_rst_stream got %0d bytes want 1", rx_q.size());
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    test_reset();
    test_char_timing();
    test_print_int_fixed();
    test_random();
    test_back_to_back_full();
    test_exit();
    test_bad();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
